// File: rtl/output_writeback.sv
// Captures a ROWS x COLS burst of PE results, clips entries outside the channel,
// and serializes the survivors as one ready/valid memory write per cycle.
module output_writeback #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int MAX_N  = 512,
  parameter int N_BITS = $clog2(MAX_N + 1),
  parameter int DATA_W = 8,
  parameter int ADDR_W = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ROWS*COLS-1:0] in_valid,
  input  logic [N_BITS-1:0]   in_row    [ROWS*COLS],
  input  logic [N_BITS-1:0]   in_col    [ROWS*COLS],
  input  logic [DATA_W-1:0]   in_data   [ROWS*COLS],
  input  logic [N_BITS-1:0]   mat_rows,
  input  logic [N_BITS-1:0]   mat_cols,
  input  logic [ADDR_W-1:0]   base_addr,
  output logic                busy,
  output logic                wr_valid,
  input  logic                wr_ready,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [DATA_W-1:0]   wr_data,
  output logic                drain_done,
  output logic                overflow_err
);

  localparam int NUM    = ROWS * COLS;
  localparam int IDX_W  = (NUM > 1) ? $clog2(NUM) : 1;
  localparam int PROD_W = 2 * N_BITS;
  localparam int SUM_W  = ((PROD_W > ADDR_W) ? PROD_W : ADDR_W) + 1;

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t              state_reg, state_next;
  logic [NUM-1:0]      pend_reg, pend_next;
  logic [NUM-1:0]      clip_mask;
  logic [NUM-1:0]      sel_onehot;
  logic [IDX_W-1:0]    sel_idx;
  logic [N_BITS-1:0]   row_reg  [NUM];
  logic [N_BITS-1:0]   col_reg  [NUM];
  logic [DATA_W-1:0]   data_reg [NUM];
  logic [N_BITS-1:0]   mat_cols_reg;
  logic [ADDR_W-1:0]   base_reg;
  logic [ADDR_W-1:0]   addr_hold_reg;
  logic [DATA_W-1:0]   data_hold_reg;
  logic                drain_done_reg, drain_done_next;
  logic                overflow_reg;
  logic                capture;
  logic                handshake;
  logic [PROD_W-1:0]   prod;
  logic [SUM_W-1:0]    sum_full;
  logic [ADDR_W-1:0]   sel_addr;

  genvar gi;
  generate
    for (gi = 0; gi < NUM; gi++) begin : g_clip
      assign clip_mask[gi] = in_valid[gi] && (in_row[gi] < mat_rows) && (in_col[gi] < mat_cols);
    end
  endgenerate

  assign capture   = (state_reg == IDLE) && (|in_valid);
  assign wr_valid  = |pend_reg;
  assign handshake = wr_valid && wr_ready;

  // Lowest-index pending entry wins; cleared entries cost no cycles.
  always_comb begin
    sel_idx = '0;
    for (int i = NUM - 1; i >= 0; i--) begin
      if (pend_reg[i]) sel_idx = IDX_W'(i);
    end
  end
  assign sel_onehot = pend_reg & (~pend_reg + NUM'(1));

  assign prod     = PROD_W'(row_reg[sel_idx]) * PROD_W'(mat_cols_reg);
  assign sum_full = SUM_W'(base_reg) + SUM_W'(prod) + SUM_W'(col_reg[sel_idx]);
  assign sel_addr = sum_full[ADDR_W-1:0];

  always_comb begin
    state_next      = state_reg;
    pend_next       = pend_reg;
    drain_done_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|in_valid) begin
          pend_next = clip_mask;
          if (|clip_mask) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (handshake) begin
          pend_next = pend_reg & ~sel_onehot;
          if (pend_next == '0) begin
            state_next      = IDLE;
            drain_done_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      pend_reg       <= '0;
      drain_done_reg <= 1'b0;
      overflow_reg   <= 1'b0;
      addr_hold_reg  <= '0;
      data_hold_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      pend_reg       <= pend_next;
      drain_done_reg <= drain_done_next;
      if ((state_reg == DRAIN) && (|in_valid)) overflow_reg <= 1'b1;
      if (|pend_reg) begin
        addr_hold_reg <= sel_addr;
        data_hold_reg <= data_reg[sel_idx];
      end
    end
  end

  // Burst payload and channel geometry only change on an accepted capture.
  always_ff @(posedge clk) begin
    if (capture) begin
      mat_cols_reg <= mat_cols;
      base_reg     <= base_addr;
      for (int i = 0; i < NUM; i++) begin
        row_reg[i]  <= in_row[i];
        col_reg[i]  <= in_col[i];
        data_reg[i] <= in_data[i];
      end
    end
  end

  // Outputs depend only on registered state, so they hold steady under stall.
  assign wr_addr      = wr_valid ? sel_addr : addr_hold_reg;
  assign wr_data      = wr_valid ? data_reg[sel_idx] : data_hold_reg;
  assign busy         = (state_reg == DRAIN);
  assign drain_done   = drain_done_reg;
  assign overflow_err = overflow_reg;

endmodule

// File: tb/tb_output_writeback.sv
// Bench for output_writeback: directed vector table, mid-drain reset sequence,
// and randomized bursts checked against a queue-based reference model.
module tb_output_writeback;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int NUM    = ROWS * COLS;
  localparam int N_BITS = 10;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 20;

  logic                clk;
  logic                reset;
  logic [NUM-1:0]      in_valid;
  logic [N_BITS-1:0]   in_row  [NUM];
  logic [N_BITS-1:0]   in_col  [NUM];
  logic [DATA_W-1:0]   in_data [NUM];
  logic [N_BITS-1:0]   mat_rows;
  logic [N_BITS-1:0]   mat_cols;
  logic [ADDR_W-1:0]   base_addr;
  logic                busy;
  logic                wr_valid;
  logic                wr_ready;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic                drain_done;
  logic                overflow_err;

  output_writeback #(
    .ROWS(ROWS), .COLS(COLS), .MAX_N(512), .N_BITS(N_BITS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_row(in_row), .in_col(in_col),
    .in_data(in_data), .mat_rows(mat_rows), .mat_cols(mat_cols), .base_addr(base_addr),
    .busy(busy), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .drain_done(drain_done), .overflow_err(overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Observed writes, captured half a cycle away from the active edge.
  logic [ADDR_W-1:0] got_addr [$];
  logic [DATA_W-1:0] got_data [$];
  int                got_cyc  [$];
  int                done_cnt, done_cyc, busy_cnt;
  logic              stall_prev = 1'b0;
  logic [ADDR_W-1:0] addr_prev;
  logic [DATA_W-1:0] data_prev;

  always @(negedge clk) begin
    if (!reset) begin
      if (stall_prev) begin
        chk("stall_hold_valid", wr_valid, 1);
        chk("stall_hold_addr", wr_addr, addr_prev);
        chk("stall_hold_data", wr_data, data_prev);
      end
      if (wr_valid && wr_ready) begin
        got_addr.push_back(wr_addr);
        got_data.push_back(wr_data);
        got_cyc.push_back(cyc);
      end
      if (drain_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) busy_cnt++;
      stall_prev = wr_valid && !wr_ready;
      addr_prev  = wr_addr;
      data_prev  = wr_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Reference model: surviving entries in index order with their word addresses.
  logic [ADDR_W-1:0] exp_addr [$];
  logic [DATA_W-1:0] exp_data [$];
  int                tcap;

  task automatic start_burst(input int r0, input int c0, input logic [NUM-1:0] mask,
                             input int mr, input int mc, input logic [ADDR_W-1:0] base);
    got_addr.delete(); got_data.delete(); got_cyc.delete();
    exp_addr.delete(); exp_data.delete();
    done_cnt = 0; busy_cnt = 0; done_cyc = -1;
    mat_rows  = N_BITS'(mr);
    mat_cols  = N_BITS'(mc);
    base_addr = base;
    for (int i = 0; i < NUM; i++) begin
      int r;
      int c;
      r = r0 + i / COLS;
      c = c0 + i % COLS;
      in_row[i]   = N_BITS'(r);
      in_col[i]   = N_BITS'(c);
      in_data[i]  = DATA_W'($urandom);
      in_valid[i] = mask[i];
      if (mask[i] && r < mr && c < mc) begin
        exp_addr.push_back(ADDR_W'((longint'(base) + longint'(r) * mc + c) % (64'd1 << ADDR_W)));
        exp_data.push_back(in_data[i]);
      end
    end
    @(posedge clk); #1;
    in_valid = '0;
    tcap = cyc;
  endtask

  // mode 0: ready always high, 1: toggling, 2: random. inj >= 0 injects a burst that cycle.
  task automatic drain(input int mode, input int inj);
    int n;
    n = exp_addr.size();
    for (int c = 0; c < 300; c++) begin
      case (mode)
        0:       wr_ready = 1'b1;
        1:       wr_ready = c[0];
        default: wr_ready = 1'($urandom_range(0, 1));
      endcase
      if (c == inj) begin
        in_valid  = '1;
        base_addr = ADDR_W'($urandom);
        for (int i = 0; i < NUM; i++) begin
          in_row[i]  = '0;
          in_col[i]  = N_BITS'(i);
          in_data[i] = DATA_W'($urandom);
        end
      end
      @(posedge clk); #1;
      in_valid = '0;
      if (n == 0 ? (c >= 5) : (done_cnt > 0)) break;
    end
    wr_ready = 1'b0;
    if (n > 0 && done_cnt == 0) chk("drain_timeout", done_cnt, 1);
  endtask

  task automatic check_writes(input string tag, input int mode);
    int n;
    int m;
    n = exp_addr.size();
    m = (got_addr.size() < n) ? got_addr.size() : n;
    chk({tag, "_write_count"}, got_addr.size(), n);
    for (int j = 0; j < m; j++) begin
      chk({tag, "_addr"}, got_addr[j], exp_addr[j]);
      chk({tag, "_data"}, got_data[j], exp_data[j]);
      if (mode == 0) chk({tag, "_write_cycle"}, got_cyc[j], tcap + j);
    end
    if (n > 0) begin
      chk({tag, "_done_count"}, done_cnt, 1);
      if (mode == 0) begin
        chk({tag, "_done_cycle"}, done_cyc, tcap + n);
        chk({tag, "_busy_cycles"}, busy_cnt, n);
      end else if (m > 0) begin
        chk({tag, "_done_cycle"}, done_cyc, got_cyc[m-1] + 1);
      end
    end else begin
      chk({tag, "_no_done"}, done_cnt, 0);
      chk({tag, "_no_busy"}, busy_cnt, 0);
    end
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_valid"}, wr_valid, 0);
    $display("[TB] %s: burst at cycle %0d, %0d writes expected, %0d observed", tag, tcap, n, got_addr.size());
  endtask

  typedef struct {
    string             name;
    int                r0, c0;
    logic [NUM-1:0]    mask;
    int                mr, mc;
    logic [ADDR_W-1:0] base;
    int                mode;
    int                inj;
    int                n;
    logic [ADDR_W-1:0] first, last;
    logic              ovf;
  } vec_t;

  vec_t vt [8];

  initial begin
    vt[0] = '{"full",      8,   4,   16'hFFFF, 32,  32,  20'h00100, 0, -1, 16, 20'h00204, 20'h00267, 1'b0};
    vt[1] = '{"sparse",    0,   0,   16'h8021, 10,  10,  20'h00000, 0, -1, 3,  20'h00000, 20'h00021, 1'b0};
    vt[2] = '{"backpress", 8,   4,   16'hFFFF, 32,  32,  20'h00100, 1, -1, 16, 20'h00204, 20'h00267, 1'b0};
    vt[3] = '{"edge_clip", 30,  30,  16'hFFFF, 32,  32,  20'h00000, 0, -1, 4,  20'd990,   20'd1023,  1'b0};
    vt[4] = '{"all_clip",  40,  40,  16'hFFFF, 32,  32,  20'h00000, 0, -1, 0,  20'h00000, 20'h00000, 1'b0};
    vt[5] = '{"addr_wrap", 0,   1,   16'h0001, 512, 512, 20'hFFFFF, 0, -1, 1,  20'h00000, 20'h00000, 1'b0};
    vt[6] = '{"big_prod",  500, 500, 16'h0001, 512, 512, 20'h80000, 0, -1, 1,  20'hBE9F4, 20'hBE9F4, 1'b0};
    vt[7] = '{"overflow",  8,   4,   16'hFFFF, 32,  32,  20'h00100, 0, 2,  16, 20'h00204, 20'h00267, 1'b1};

    reset = 1'b1; wr_ready = 1'b0; in_valid = '0;
    mat_rows = '0; mat_cols = '0; base_addr = '0;
    for (int i = 0; i < NUM; i++) begin
      in_row[i] = '0; in_col[i] = '0; in_data[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_wr_valid", wr_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_wr_addr", wr_addr, 0);
    chk("reset_wr_data", wr_data, 0);
    chk("reset_drain_done", drain_done, 0);
    chk("reset_overflow", overflow_err, 0);

    for (int k = 0; k < 8; k++) begin
      start_burst(vt[k].r0, vt[k].c0, vt[k].mask, vt[k].mr, vt[k].mc, vt[k].base);
      drain(vt[k].mode, vt[k].inj);
      check_writes(vt[k].name, vt[k].mode);
      chk({vt[k].name, "_table_count"}, got_addr.size(), vt[k].n);
      if (vt[k].n > 0 && got_addr.size() > 0) begin
        chk({vt[k].name, "_table_first"}, got_addr[0], vt[k].first);
        chk({vt[k].name, "_table_last"}, got_addr[got_addr.size()-1], vt[k].last);
      end
      chk({vt[k].name, "_overflow"}, overflow_err, vt[k].ovf);
    end

    // Reset in the middle of a drain discards the rest and clears the sticky error.
    start_burst(8, 4, 16'hFFFF, 32, 32, 20'h00100);
    wr_ready = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midreset_wr_valid", wr_valid, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_overflow", overflow_err, 0);
    chk("midreset_drain_done", drain_done, 0);
    chk("midreset_writes_before", got_addr.size(), 4);
    repeat (3) begin @(posedge clk); #1; end
    chk("midreset_no_done", done_cnt, 0);
    chk("midreset_pend_clear", wr_valid, 0);
    wr_ready = 1'b0;
    $display("[TB] midreset: burst at cycle %0d, reset after %0d writes", tcap, got_addr.size());
    start_burst(0, 0, 16'hFFFF, 4, 4, 20'h00040);
    drain(0, -1);
    check_writes("after_reset", 0);
    if (got_addr.size() > 0) chk("after_reset_first_idx0", got_addr[0], 20'h00040);

    for (int k = 0; k < 40; k++) begin
      int r0;
      int c0;
      r0 = (k % 4 == 0) ? $urandom_range(0, 600) : $urandom_range(0, 40);
      c0 = (k % 4 == 0) ? $urandom_range(0, 600) : $urandom_range(0, 40);
      start_burst(r0, c0, NUM'($urandom), $urandom_range(1, 512) % ((k % 4 == 0) ? 512 : 40) + 1,
                  $urandom_range(1, 512) % ((k % 4 == 0) ? 512 : 40) + 1, ADDR_W'($urandom));
      drain(2, -1);
      check_writes("random", 2);
      chk("random_overflow", overflow_err, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
